// File: rtl/mem_port_arbiter_if.sv
// Wishbone-style memory port shared by the IF and MEM stages.
// The arbiter is the bus master; the memory (or its model) is the slave.
interface mem_port_arbiter_if;
    logic        bus_cyc;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: one non-abortable bus transaction at a time, shared
// between instruction fetch (read-only) and the data stage. Data has priority
// unless fetch has been passed over STARVE_MAX times in a row. A flush lets
// the in-flight bus cycle finish and throws its result away.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,

    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    output logic [31:0]          i_rdata,
    output logic                 i_rdy,
    output logic                 stallreq_if,

    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [3:0]           d_sel,
    input  logic [31:0]          d_addr,
    input  logic [31:0]          d_wdata,
    output logic [31:0]          d_rdata,
    output logic                 d_rdy,
    output logic                 stallreq_mem,

    mem_port_arbiter_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    state_t      r_state;
    state_t      w_next_state;

    logic [3:0]  r_starve_cnt;

    logic        r_bus_cyc;
    logic        r_bus_we;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        r_i_rdy;
    logic        r_d_rdy;

    logic        w_turnaround;
    logic        w_inst_forced;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_release;
    logic        w_deliver;

    // A cycle right after a completion (or any flush cycle) never grants, so a
    // request the stage has not yet dropped is not issued a second time.
    assign w_turnaround  = flush | r_i_rdy | r_d_rdy;
    assign w_inst_forced = i_req & (r_starve_cnt >= STARVE_LIMIT);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle grant/completion decisions.
    always_comb begin
        // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_release    = 1'b0;
        w_deliver    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_turnaround) begin
                    if (d_req && !w_inst_forced) begin
                        w_grant_d    = 1'b1;
                        w_next_state = GRANT_D;
                    end else if (i_req) begin
                        w_grant_i    = 1'b1;
                        w_next_state = GRANT_I;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                if (bus.bus_ack) begin
                    w_release    = 1'b1;
                    w_deliver    = ~flush;
                    w_next_state = IDLE;
                end else if (flush) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                // The bus cannot abort: wait for the ack, deliver nothing.
                if (bus.bus_ack) begin
                    w_release    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Bus request registers and result/completion registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_cyc   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'h0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_i_rdata   <= 32'h0;
            r_d_rdata   <= 32'h0;
            r_i_rdy     <= 1'b0;
            r_d_rdy     <= 1'b0;
        end else begin
            r_i_rdy <= 1'b0;
            r_d_rdy <= 1'b0;

            if (w_grant_d) begin
                r_bus_cyc   <= 1'b1;
                r_bus_we    <= d_we;
                r_bus_sel   <= d_sel;
                r_bus_addr  <= d_addr;
                r_bus_wdata <= d_wdata;
            end else if (w_grant_i) begin
                r_bus_cyc   <= 1'b1;
                r_bus_we    <= 1'b0;
                r_bus_sel   <= 4'hF;
                r_bus_addr  <= i_addr;
                r_bus_wdata <= 32'h0;
            end else if (w_release) begin
                r_bus_cyc   <= 1'b0;
            end

            if (w_deliver) begin
                if (r_state == GRANT_I) begin
                    r_i_rdata <= bus.bus_rdata;
                    r_i_rdy   <= 1'b1;
                end else begin
                    r_d_rdy <= 1'b1;
                    // Stores complete with a pulse but leave the load data alone.
                    if (!r_bus_we) begin
                        r_d_rdata <= bus.bus_rdata;
                    end
                end
            end
        end
    end

    // Counts data grants that passed over a waiting fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= 4'h0;
        end else if (!i_req || w_grant_i) begin
            r_starve_cnt <= 4'h0;
        end else if (w_grant_d && (r_starve_cnt != 4'hF)) begin
            r_starve_cnt <= r_starve_cnt + 4'h1;
        end
    end

    assign bus.bus_cyc   = r_bus_cyc;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_sel   = r_bus_sel;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;

    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_rdy   = r_i_rdy;
    assign d_rdy   = r_d_rdy;

    // Stall requests drop in the completion cycle and are held low in reset.
    assign stallreq_if  = rst & i_req & ~r_i_rdy;
    assign stallreq_mem = rst & d_req & ~r_d_rdy;

endmodule
